// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg
// Shared encodings for the multicycle RV32I controller and its datapath:
// FSM state type, opcodes, ALUOp classes, ALUControl codes and the
// ResultSrc / ALUSrcA / ALUSrcB / ImmSrc mux select encodings.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALUOp classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl codes
  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format implied by an opcode; unknown opcodes default to I.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:     imm_src_of = IMM_S;
      OP_BRANCH: imm_src_of = IMM_B;
      OP_JAL:    imm_src_of = IMM_J;
      default:   imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_controller_alu_decoder.sv
// alu_decoder
// Maps the FSM's ALUOp class plus instruction fields onto an ALUControl code.
// Ports:
//   i_alu_op     ALUOp class (add / sub / funct)
//   i_funct3     Instr[14:12]
//   i_funct7b5   Instr[30]
//   i_op5        Instr[5]; distinguishes R-type (sub allowed) from I-type
//   o_alu_control ALU operation code
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALUC_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // addi has no sub form, so Instr[30] only matters for R-type
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  o_alu_control = ALUC_SLT;
          3'b110:  o_alu_control = ALUC_OR;
          3'b111:  o_alu_control = ALUC_AND;
          default: o_alu_control = ALUC_ADD;
        endcase
      end
      default: o_alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller
// Control FSM for the multicycle RV32I core. Moore state outputs, a
// combinational ALU decoder and a branch-qualified PCWrite.
// Ports:
//   clk, rst (asynchronous, active-low)
//   op, funct3, funct7b5, zero          instruction fields and ALU flag
//   ResultSrc, ALUControl, ALUSrcA, ALUSrcB, ImmSrc, AdrSrc   selects
//   RegWrite, IRWrite, PCWrite, MemWrite                     write enables
//   illegal                             unsupported opcode seen in DECODE
module riscv_mc_controller
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_alu_op;
  logic       w_reg_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_mem_write;
  logic       w_illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTER;
          OP_ITYPE:     w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BRANCH:    w_next = S_BRANCH;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_WDATA;
    ImmSrc      = IMM_I;
    AdrSrc      = 1'b0;
    w_alu_op    = ALUOP_ADD;
    w_reg_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = imm_src_of(op);
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH: w_illegal = 1'b0;
          default:                                             w_illegal = 1'b1;
        endcase
      end
      // The immediate is consumed again here, so its format stays selected.
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = imm_src_of(op);
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA  = SRCA_A;
        w_alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA  = SRCA_A;
        ALUSrcB  = SRCB_IMM;
        ImmSrc   = IMM_I;
        w_alu_op = ALUOP_FUNCT;
      end
      S_ALUWB:    w_reg_write = 1'b1;
      // ALU forms oldPC+4 for rd while the PC loads the target held in ALUOut.
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        w_pc_write = 1'b1;
      end
      // beq takes the branch on zero, bne on !zero.
      S_BRANCH: begin
        ALUSrcA    = SRCA_A;
        w_alu_op   = ALUOP_SUB;
        w_pc_write = zero ^ funct3[0];
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op5         (op[5]),
    .o_alu_control (ALUControl)
  );

  // Reset masks every enable combinationally so nothing commits while held.
  assign RegWrite = w_reg_write & rst;
  assign IRWrite  = w_ir_write  & rst;
  assign PCWrite  = w_pc_write  & rst;
  assign MemWrite = w_mem_write & rst;
  assign illegal  = w_illegal   & rst;

endmodule

// File: tb/tb_riscv_mc_controller.sv
module tb_riscv_mc_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] ResultSrc;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       MemWrite;
  logic       illegal;

  int n_cmp;
  int n_err;

  riscv_mc_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ResultSrc, ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegWrite, AdrSrc,
  //  IRWrite, PCWrite, MemWrite, illegal}
  logic [16:0] got;
  assign got = {ResultSrc, ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegWrite,
                AdrSrc, IRWrite, PCWrite, MemWrite, illegal};

  function automatic logic [16:0] mk(input logic [1:0] rs, input logic [2:0] ac,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] imm, input logic rw,
                                     input logic adr, input logic irw,
                                     input logic pcw, input logic mw,
                                     input logic ill);
    return {rs, ac, a, b, imm, rw, adr, irw, pcw, mw, ill};
  endfunction

  // Instruction classes from the opcode
  function automatic int kind_of(input logic [6:0] o);
    case (o)
      7'b0000011: return 1; // lw
      7'b0100011: return 2; // sw
      7'b0110011: return 3; // R
      7'b0010011: return 4; // I
      7'b1101111: return 5; // jal
      7'b1100011: return 6; // branch
      default:    return 0; // illegal
    endcase
  endfunction

  function automatic int latency(input logic [6:0] o);
    case (kind_of(o))
      1:       return 5;
      2, 3, 4, 5: return 4;
      6:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] imm_fmt(input logic [6:0] o);
    case (kind_of(o))
      2:       return 2'b01;
      6:       return 2'b10;
      5:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // ALU operation chosen by funct fields: add/sub/slt/or/and
  function automatic logic [2:0] alu_fn(input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Required outputs in cycle 'step' of an instruction (step 0 = FETCH)
  function automatic logic [16:0] expect_out(input logic [6:0] o, input logic [2:0] f3,
                                             input logic f7, input logic z,
                                             input int step);
    int k;
    k = kind_of(o);
    if (step == 0) return mk(2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 0, 0, 1, 1, 0, 0);
    if (step == 1) return mk(2'b00, 3'b000, 2'b01, 2'b01, imm_fmt(o), 0, 0, 0, 0, 0, k == 0);
    if (step == 2) begin
      case (k)
        1, 2:    return mk(2'b00, 3'b000, 2'b10, 2'b01, imm_fmt(o), 0, 0, 0, 0, 0, 0);
        3:       return mk(2'b00, alu_fn(o, f3, f7), 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        4:       return mk(2'b00, alu_fn(o, f3, f7), 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
        5:       return mk(2'b00, 3'b000, 2'b01, 2'b10, 2'b00, 0, 0, 0, 1, 0, 0);
        default: return mk(2'b00, 3'b001, 2'b10, 2'b00, 2'b00, 0, 0, 0, z ^ f3[0], 0, 0);
      endcase
    end
    if (step == 3) begin
      case (k)
        1:       return mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0);
        2:       return mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 1, 0);
        default: return mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
      endcase
    end
    return mk(2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
  endfunction

  logic [16:0] rst_vec;
  assign rst_vec = mk(2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);

  task automatic check(input string tag, input logic [16:0] e);
    n_cmp++;
    assert (got === e) else begin
      n_err++;
      $error("FAIL %s observed=%05h expected=%05h", tag, got, e);
    end
  endtask

  // Runs one instruction starting in its FETCH cycle (called just after a
  // rising edge). zmode: 0/1 fixed zero, 2 random. abort_at >= 0 asserts
  // reset after that step has been checked.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zmode, input int abort_at);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int s = 0; s < latency(o); s++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      @(negedge clk);
      check($sformatf("%s step%0d", name, s), expect_out(o, f3, f7, zero, s));
      if (s == abort_at) begin
        rst = 1'b0;
        #1 check($sformatf("%s abort", name), rst_vec);
        @(posedge clk); #1;
        check($sformatf("%s abort hold", name), rst_vec);
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  logic [6:0] bad_ops [7];

  initial begin
    n_cmp = 0; n_err = 0;
    bad_ops = '{7'b0110111, 7'b0010111, 7'b1100111, 7'b1110011,
                7'b0001111, 7'b0000000, 7'b1111111};
    rst = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset cyc%0d", i), rst_vec);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    run_instr("lw",     7'b0000011, 3'b010, 1'b0, 2, -1);
    run_instr("sub",    7'b0110011, 3'b000, 1'b1, 2, -1);
    run_instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 1, -1);
    run_instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 0, -1);
    run_instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 0, -1);
    run_instr("bne_z1", 7'b1100011, 3'b001, 1'b0, 1, -1);
    run_instr("sw",     7'b0100011, 3'b010, 1'b0, 2, -1);
    run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 2, -1);
    run_instr("jal",    7'b1101111, 3'b000, 1'b0, 2, -1);
    run_instr("illegal", 7'b0110111, 3'b000, 1'b0, 2, -1);
    run_instr("lw_abort", 7'b0000011, 3'b010, 1'b0, 2, 2);
    run_instr("lw_after", 7'b0000011, 3'b010, 1'b0, 2, -1);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      int k;
      k = $urandom_range(0, 6);
      case (k)
        1: o = 7'b0000011;
        2: o = 7'b0100011;
        3: o = 7'b0110011;
        4: o = 7'b0010011;
        5: o = 7'b1101111;
        6: o = 7'b1100011;
        default: o = bad_ops[$urandom_range(0, 6)];
      endcase
      run_instr($sformatf("rnd%0d", n), o, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 2,
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, latency(o) - 1) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_mc_controller.md
# riscv_mc_controller

Control FSM for the multicycle RV32I core. Sits directly upstream of the datapath: it consumes the latched instruction fields and the ALU `zero` flag, and produces every mux select, ALU operation and write enable the datapath and unified memory need each cycle. Moore-style state outputs, plus a combinational ALU decoder and a branch-qualified `PCWrite`.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-low.
- `op`  in  7  `Instr[6:0]` from the instruction register.
- `funct3`  in  3  `Instr[14:12]`.
- `funct7b5`  in  1  `Instr[30]`.
- `zero`  in  1  ALU zero flag for the current cycle.
- `ResultSrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ALUSrcA`  out  2  00 PC, 01 oldPC, 10 A register.
- `ALUSrcB`  out  2  00 WriteData, 01 immExt, 10 constant 4.
- `ImmSrc`  out  2  00 I, 01 S, 10 B, 11 J.
- `RegWrite`  out  1  register-file write enable.
- `AdrSrc`  out  1  0 PC, 1 Result.
- `IRWrite`  out  1  instruction-register and oldPC load.
- `PCWrite`  out  1  PC load.
- `MemWrite`  out  1  data-memory write enable.
- `illegal`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BRANCH.
- FETCH: `AdrSrc`=0, `IRWrite`=1, `ALUSrcA`=00, `ALUSrcB`=10, ALUOp add, `ResultSrc`=10, `PCWrite`=1. Next state is DECODE.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=01, ALUOp add (computes the branch target into ALUOut). `ImmSrc` is driven from `op`. Transitions by `op`:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100011 → BRANCH
  - any other opcode → FETCH, with `illegal`=1.
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `ResultSrc`=00, `AdrSrc`=1 → MEMWB.
- MEMWB: `ResultSrc`=01, `RegWrite`=1 → FETCH.
- MEMWRITE: `ResultSrc`=00, `AdrSrc`=1, `MemWrite`=1 → FETCH.
- EXECUTER: `ALUSrcA`=10, `ALUSrcB`=00, ALUOp funct → ALUWB.
- EXECUTEI: `ALUSrcA`=10, `ALUSrcB`=01, ALUOp funct → ALUWB.
- ALUWB: `ResultSrc`=00, `RegWrite`=1 → FETCH.
- JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ResultSrc`=00, `PCWrite`=1 → ALUWB. The ALU computes oldPC+4 while the target is taken from ALUOut.
- BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, sub, `ResultSrc`=00. `PCWrite` = `zero` XOR `funct3[0]`, which covers beq and bne. Next state is FETCH.
- ALU decoder, active when ALUOp=funct:
  - funct3 000: sub if `op[5]`&`funct7b5`, else add.
  - 010 → slt; 110 → or; 111 → and.
  - any other funct3 → add.
- Unused outputs in each state are driven 0. No X on any output in any state.

## Timing
- Reset (`rst` low): state is forced to FETCH asynchronously. All write enables (`PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`) and `illegal` are forced 0 while reset is asserted. Selects take their FETCH values.
- On the first rising edge after `rst` deasserts, the FETCH outputs are active.
- Reset asserted mid-instruction aborts it immediately. No partial register or memory write may occur after reset assertion.
- Instruction latency, in cycles from FETCH through the return to FETCH:
  - lw 5
  - sw 4, R-type 4, I-type 4, jal 4
  - beq/bne 3
  - illegal opcode 2
- `PCWrite` in BRANCH is combinational on `zero` within the same cycle. Every other output depends only on registered state, `op` and `funct3`.
- `ALUControl` is combinational from the state's ALUOp and the instruction fields.

## Structure
- Package `riscv_mc_pkg`:
  - `state_t` enum
  - opcode localparams
  - ALUOp (add/sub/funct) and `ALUControl` code constants
  - `ResultSrc`, `ALUSrcA`, `ALUSrcB` and `ImmSrc` encodings, shared with the datapath.
- Sub-module `alu_decoder` holds the ALUOp/funct3/funct7b5/op[5] → `ALUControl` logic.
- The FSM (state register, next-state logic, output decode) stays in `riscv_mc_controller`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release. Required: `IRWrite`=`PCWrite`=`RegWrite`=`MemWrite`=0 during reset; `IRWrite`=`PCWrite`=1, `ALUSrcB`=10 in the first cycle after release.
- lw (`op`=0000011): state sequence FETCH→DECODE→MEMADR→MEMREAD→MEMWB. `RegWrite`=1 with `ResultSrc`=01 in cycle 5 only.
- sub (`op`=0110011, `funct3`=000, `funct7b5`=1): `ALUControl`=001 in EXECUTER. `RegWrite`=1 in ALUWB. Back to FETCH at cycle 5.
- beq with `zero`=1, then again with `zero`=0: `PCWrite`=1 in BRANCH for the first and 0 for the second. bne (`funct3`=001) with `zero`=0 gives `PCWrite`=1.
- sw: `MemWrite`=1 and `AdrSrc`=1 in cycle 4 only. `RegWrite` stays 0 throughout.
- `op`=0110111 (unsupported): `illegal` pulses in DECODE and the FSM returns to FETCH. Then assert `rst` during MEMADR of an lw: no `RegWrite` occurs and the FSM restarts at FETCH.
